cram_axi_responder: RTL and testbench
=====================================

# cram_axi_responder

AXI4 read-only responder serving the constant/instruction RAM (CRAM) to the MMU's CRAM read port. It accepts one burst at a time on AR and returns `arlen+1` 32-bit beats on R from an internal single-port synchronous RAM. A simple host load port fills the RAM before kernels run. It is the slave end of the `cram_ar*`/`cram_r*` channel.

## Interface
- `ID_WIDTH`, 4, AXI ID width.
- `CRAM_ADDR_W`, 12, byte-address width of CRAM. Depth is 2**(CRAM_ADDR_W-2) 32-bit words.
- `clk` in 1: single clock, rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `cram_arid` in ID_WIDTH: read ID.
- `cram_araddr` in 32: byte address. Bits [1:0] are ignored.
- `cram_arlen` in 8: beats minus 1.
- `cram_arsize` in 3: only 3'h2 (4 bytes) is supported.
- `cram_arburst` in 2: only 2'b01 (INCR) is supported.
- `cram_arlock`, `cram_arcache`, `cram_arprot`, `cram_arqos` in 1/4/3/4: ignored.
- `cram_arvalid` in 1, `cram_arready` out 1: AR handshake.
- `cram_rid` out ID_WIDTH: echoes the latched `arid`.
- `cram_rdata` out 32: read word.
- `cram_rresp` out 2: 2'b00 OKAY, 2'b10 SLVERR.
- `cram_rlast` out 1: final beat of the burst.
- `cram_rvalid` out 1, `cram_rready` in 1: R handshake.
- `ld_valid` in 1, `ld_ready` out 1: load-port handshake.
- `ld_addr` in CRAM_ADDR_W-2: word index to write.
- `ld_data` in 32: word to write.

## Operation
- FSM states: IDLE, FETCH, SEND.
- **IDLE**
  - `cram_arready`=1.
  - On AR handshake, latch id, the word address `araddr[31:2]` (30-bit), `arlen` into a beat counter, and an error flag.
  - Error flag = (arsize != 3'h2) | (arburst != 2'b01).
  - Next state is FETCH.
- **FETCH**
  - `cram_arready`=0 and `ld_ready`=0.
  - RAM read enable is asserted at the current word address if the address is in range.
  - Beat out-of-range: any address bit at or above CRAM_ADDR_W-2 is set.
  - Out-of-range sets the sticky per-burst error flag.
  - Next state is SEND.
- **SEND**
  - `cram_rvalid`=1.
  - If the error flag is clear: `rdata` = RAM output, `rresp`=2'b00.
  - If the error flag is set: `rdata`=0, `rresp`=2'b10.
  - `rlast`=(beat counter==0).
  - All R outputs hold stable while `rready`=0.
  - On R handshake:
    - If `rlast`: next state is IDLE.
    - Otherwise: decrement the counter, increment the word address (30-bit, wraps mod 2^30), and go to FETCH.
- Error flag is sticky: once a beat errs, every remaining beat of that burst returns SLVERR.
  - A word-address wrap past 2^30-1 does not clear it.
- Once an in-range burst crosses the end of CRAM, the remaining beats are SLVERR.
- **Load port**
  - `ld_ready`=1 in IDLE and SEND, 0 in FETCH.
  - A write occurs on the `ld_valid`&`ld_ready` cycle.
  - RAM read enable is only high in FETCH, so a write during SEND does not disturb the RAM output register.
  - A write to the word currently being returned is not visible until the next FETCH of that word.
- Only one burst is outstanding. There is no read reordering and no write channels.

## Timing
- Reset (`nrst`=0, asynchronous):
  - State is IDLE.
  - `cram_arready`=0, `cram_rvalid`=0, `cram_rlast`=0, `cram_rresp`=0, `cram_rid`=0, `cram_rdata`=0, `ld_ready`=0.
  - RAM contents are not cleared.
- `cram_arready` and `ld_ready` are registered.
  - Both rise on the first clock edge after `nrst` deasserts.
  - `cram_arready` deasserts the cycle after an AR handshake.
- AR handshake at edge T: FETCH in cycle T+1; `rvalid`=1 with the first beat in cycle T+2.
- Each beat takes 2 cycles minimum (FETCH, SEND).
  - Burst of N beats with `rready` tied 1: the last handshake is at T+2N.
  - IDLE (`arready`=1) follows at T+2N+1.
- Reset asserted mid-burst: outputs go to reset values immediately. The burst is abandoned with no rlast.
- `arvalid` outside IDLE is ignored until `arready`=1.

## Test plan
- Load words 0..15 with value 0xC0DE0000+i, then AR `araddr`=0x10, `arlen`=3, `arid`=5, `rready`=1.
  - Expect 4 beats with data 0xC0DE0004..0xC0DE0007, `rid`=5, `rresp`=0, `rlast` on beat 4 only.
  - First `rvalid` is 2 cycles after AR.
- Same burst with `rready` toggled randomly.
  - Data, `rresp` and `rlast` must be stable while stalled.
  - No beat may be lost or duplicated.
- CRAM_ADDR_W=12, AR `araddr`=0xFF8, `arlen`=3.
  - Beats 1–2 are OKAY with RAM data.
  - Beats 3–4 are SLVERR with data 0.
- AR with `arsize`=3'h3, `arlen`=1: two SLVERR beats with data 0, `rlast` on the second.
- Hold `ld_valid`=1 through a burst.
  - `ld_ready` is 0 in every FETCH cycle.
  - Writes land only in IDLE/SEND.
  - The returned beat holds its pre-write value if written during its SEND.
- Assert `nrst` during the SEND of beat 2 of 4.
  - All outputs go to reset values at once.
  - After release, `arready`=1 and a new burst completes correctly.

Source files
------------

// File: rtl/cram_axi_responder.sv
// AXI4 read-only responder for the constant/instruction RAM: one INCR burst at a
// time on AR/R, served from a single-port synchronous RAM with a host load port.
module cram_axi_responder #(
  parameter int ID_WIDTH    = 4,
  parameter int CRAM_ADDR_W = 12
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [ID_WIDTH-1:0]    cram_arid,
  input  logic [31:0]            cram_araddr,
  input  logic [7:0]             cram_arlen,
  input  logic [2:0]             cram_arsize,
  input  logic [1:0]             cram_arburst,
  input  logic                   cram_arlock,
  input  logic [3:0]             cram_arcache,
  input  logic [2:0]             cram_arprot,
  input  logic [3:0]             cram_arqos,
  input  logic                   cram_arvalid,
  output logic                   cram_arready,
  output logic [ID_WIDTH-1:0]    cram_rid,
  output logic [31:0]            cram_rdata,
  output logic [1:0]             cram_rresp,
  output logic                   cram_rlast,
  output logic                   cram_rvalid,
  input  logic                   cram_rready,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [CRAM_ADDR_W-3:0] ld_addr,
  input  logic [31:0]            ld_data
);

  localparam int WORD_W = CRAM_ADDR_W - 2;
  localparam int DEPTH  = 1 << WORD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_e;

  state_e              state_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [29:0]         addr_q;
  logic [7:0]          cnt_q;
  logic                err_q;
  logic                arready_q;
  logic                ld_ready_q;
  logic                rvalid_q;
  logic                rlast_q;
  logic [1:0]          rresp_q;
  logic [31:0]         rdout_q;
  logic [31:0]         mem_q [DEPTH];

  logic              ar_hs_s;
  logic              r_hs_s;
  logic              ld_we_s;
  logic              oor_s;
  logic              ram_re_s;
  logic              bad_req_s;
  logic [WORD_W-1:0] word_idx_s;
  logic              unused_s;

  assign ar_hs_s    = arready_q & cram_arvalid;
  assign r_hs_s     = rvalid_q & cram_rready;
  assign ld_we_s    = ld_valid & ld_ready_q;
  assign oor_s      = |addr_q[29:WORD_W];
  assign word_idx_s = addr_q[WORD_W-1:0];
  assign ram_re_s   = (state_q == FETCH) & ~oor_s;
  assign bad_req_s  = (cram_arsize != 3'h2) | (cram_arburst != 2'b01);
  assign unused_s   = ^{cram_arlock, cram_arcache, cram_arprot, cram_arqos, cram_araddr[1:0]};

  // Loads never coincide with reads: ld_ready is low exactly when the RAM is read.
  always_ff @(posedge clk) begin
    if (ld_we_s) mem_q[ld_addr] <= ld_data;
    if (ram_re_s) rdout_q <= mem_q[word_idx_s];
  end

  // Burst sequencer with registered handshake and response outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      addr_q     <= 30'd0;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      arready_q  <= 1'b0;
      ld_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_hs_s) begin
            id_q       <= cram_arid;
            addr_q     <= cram_araddr[31:2];
            cnt_q      <= cram_arlen;
            err_q      <= bad_req_s;
            arready_q  <= 1'b0;
            ld_ready_q <= 1'b0;
            state_q    <= FETCH;
          end else begin
            arready_q  <= 1'b1;
            ld_ready_q <= 1'b1;
          end
        end
        FETCH: begin
          // Error is sticky for the rest of the burst, including across address wrap.
          err_q      <= err_q | oor_s;
          rresp_q    <= (err_q | oor_s) ? 2'b10 : 2'b00;
          rlast_q    <= (cnt_q == 8'd0);
          rvalid_q   <= 1'b1;
          ld_ready_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          if (r_hs_s) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= 2'b00;
            if (rlast_q) begin
              arready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              cnt_q      <= cnt_q - 8'd1;
              addr_q     <= addr_q + 30'd1;
              ld_ready_q <= 1'b0;
              state_q    <= FETCH;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cram_arready = arready_q;
  assign ld_ready     = ld_ready_q;
  assign cram_rvalid  = rvalid_q;
  assign cram_rlast   = rlast_q;
  assign cram_rresp   = rresp_q;
  assign cram_rid     = id_q;
  // Data is forced to zero outside SEND and on errored beats.
  assign cram_rdata   = (rvalid_q && !err_q) ? rdout_q : 32'd0;

endmodule

// File: tb/tb_cram_axi_responder.sv
// Directed bench for cram_axi_responder: reset values, bursts at full speed and
// with stalls, end-of-CRAM and bad-size errors, load-port interplay, mid-burst reset.
module tb_cram_axi_responder;

  logic        clk;
  logic        nrst;
  logic [3:0]  cram_arid;
  logic [31:0] cram_araddr;
  logic [7:0]  cram_arlen;
  logic [2:0]  cram_arsize;
  logic [1:0]  cram_arburst;
  logic        cram_arlock;
  logic [3:0]  cram_arcache;
  logic [2:0]  cram_arprot;
  logic [3:0]  cram_arqos;
  logic        cram_arvalid;
  logic        cram_arready;
  logic [3:0]  cram_rid;
  logic [31:0] cram_rdata;
  logic [1:0]  cram_rresp;
  logic        cram_rlast;
  logic        cram_rvalid;
  logic        cram_rready;
  logic        ld_valid;
  logic        ld_ready;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_id = 4'd0;

  cram_axi_responder #(.ID_WIDTH(4), .CRAM_ADDR_W(12)) dut (
    .clk(clk), .nrst(nrst),
    .cram_arid(cram_arid), .cram_araddr(cram_araddr), .cram_arlen(cram_arlen),
    .cram_arsize(cram_arsize), .cram_arburst(cram_arburst), .cram_arlock(cram_arlock),
    .cram_arcache(cram_arcache), .cram_arprot(cram_arprot), .cram_arqos(cram_arqos),
    .cram_arvalid(cram_arvalid), .cram_arready(cram_arready),
    .cram_rid(cram_rid), .cram_rdata(cram_rdata), .cram_rresp(cram_rresp),
    .cram_rlast(cram_rlast), .cram_rvalid(cram_rvalid), .cram_rready(cram_rready),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    int n = 0;
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    while (!ld_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
    int n = 0;
    cram_arvalid = 1'b1;
    cram_arid    = id;
    cram_araddr  = addr;
    cram_arlen   = len;
    cram_arsize  = size;
    cram_arburst = 2'b01;
    while (!cram_arready && n < 20) begin
      tick();
      n++;
    end
    check("ar_ready", 32'(cram_arready), 32'd1);
    tick();
    cram_arvalid = 1'b0;
    exp_id = id;
    check("ar_drop", 32'(cram_arready), 32'd0);
    check("fetch_rvalid", 32'(cram_rvalid), 32'd0);
  endtask

  task automatic recv_beat(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                           input logic exp_last, input bit stall);
    int waited = 0;
    int k;
    while (!cram_rvalid && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_rvalid"}, 32'(cram_rvalid), 32'd1);
    check({tag, "_lat"}, 32'(waited), 32'd1);
    check({tag, "_data"}, cram_rdata, exp_data);
    check({tag, "_resp"}, 32'(cram_rresp), 32'(exp_resp));
    check({tag, "_last"}, 32'(cram_rlast), 32'(exp_last));
    check({tag, "_id"}, 32'(cram_rid), 32'(exp_id));
    if (stall) begin
      k = $urandom_range(1, 3);
      cram_rready = 1'b0;
      for (int i = 0; i < k; i++) begin
        tick();
        check({tag, "_hold_valid"}, 32'(cram_rvalid), 32'd1);
        check({tag, "_hold_data"}, cram_rdata, exp_data);
        check({tag, "_hold_resp"}, 32'(cram_rresp), 32'(exp_resp));
        check({tag, "_hold_last"}, 32'(cram_rlast), 32'(exp_last));
      end
    end
    cram_rready = 1'b1;
    tick();
    if (stall) cram_rready = 1'b0;
    check({tag, "_after_rvalid"}, 32'(cram_rvalid), 32'd0);
    if (exp_last) check({tag, "_idle_arready"}, 32'(cram_arready), 32'd1);
    else          check({tag, "_fetch_ldready"}, 32'(ld_ready), 32'd0);
  endtask

  initial begin
    nrst = 1'b0;
    cram_arid = 4'd0; cram_araddr = 32'd0; cram_arlen = 8'd0; cram_arsize = 3'h2;
    cram_arburst = 2'b01; cram_arlock = 1'b0; cram_arcache = 4'd0; cram_arprot = 3'd0;
    cram_arqos = 4'd0; cram_arvalid = 1'b0; cram_rready = 1'b0;
    ld_valid = 1'b0; ld_addr = 10'd0; ld_data = 32'd0;

    tick();
    tick();
    check("rst_arready", 32'(cram_arready), 32'd0);
    check("rst_ldready", 32'(ld_ready), 32'd0);
    check("rst_rvalid", 32'(cram_rvalid), 32'd0);
    check("rst_rlast", 32'(cram_rlast), 32'd0);
    check("rst_rresp", 32'(cram_rresp), 32'd0);
    check("rst_rid", 32'(cram_rid), 32'd0);
    check("rst_rdata", cram_rdata, 32'd0);
    nrst = 1'b1;
    check("rel_arready_still0", 32'(cram_arready), 32'd0);
    tick();
    check("rel_arready", 32'(cram_arready), 32'd1);
    check("rel_ldready", 32'(ld_ready), 32'd1);

    for (int i = 0; i < 16; i++) load(10'(i), 32'hC0DE0000 + 32'(i));
    load(10'h3FE, 32'hAAAA03FE);
    load(10'h3FF, 32'hAAAA03FF);

    // Full-speed 4-beat burst
    cram_rready = 1'b1;
    send_ar(4'd5, 32'h10, 8'd3, 3'h2);
    for (int b = 0; b < 4; b++)
      recv_beat($sformatf("fast%0d", b), 32'hC0DE0004 + 32'(b), 2'b00, (b == 3), 1'b0);

    // Same burst with random stalls
    cram_rready = 1'b0;
    send_ar(4'd5, 32'h10, 8'd3, 3'h2);
    for (int b = 0; b < 4; b++)
      recv_beat($sformatf("stall%0d", b), 32'hC0DE0004 + 32'(b), 2'b00, (b == 3), 1'b1);

    // Burst crossing the end of CRAM
    send_ar(4'd2, 32'hFF8, 8'd3, 3'h2);
    recv_beat("end0", 32'hAAAA03FE, 2'b00, 1'b0, 1'b0);
    recv_beat("end1", 32'hAAAA03FF, 2'b00, 1'b0, 1'b0);
    recv_beat("end2", 32'd0, 2'b10, 1'b0, 1'b0);
    recv_beat("end3", 32'd0, 2'b10, 1'b1, 1'b0);

    // Unsupported size
    send_ar(4'd9, 32'h0, 8'd1, 3'h3);
    recv_beat("size0", 32'd0, 2'b10, 1'b0, 1'b0);
    recv_beat("size1", 32'd0, 2'b10, 1'b1, 1'b0);

    // Load port held active through a stalled burst
    cram_rready = 1'b0;
    send_ar(4'd3, 32'h20, 8'd1, 3'h2);
    ld_valid = 1'b1; ld_addr = 10'd8; ld_data = 32'h55550008;
    check("ld_fetch0_ready", 32'(ld_ready), 32'd0);
    tick();
    check("ld_send0_ready", 32'(ld_ready), 32'd1);
    check("ld_send0_data", cram_rdata, 32'hC0DE0008);
    tick();
    check("ld_send0_hold", cram_rdata, 32'hC0DE0008);
    cram_rready = 1'b1;
    tick();
    cram_rready = 1'b0;
    check("ld_fetch1_ready", 32'(ld_ready), 32'd0);
    check("ld_fetch1_rvalid", 32'(cram_rvalid), 32'd0);
    ld_addr = 10'd9; ld_data = 32'h55550009;
    tick();
    check("ld_send1_data", cram_rdata, 32'hC0DE0009);
    check("ld_send1_last", 32'(cram_rlast), 32'd1);
    tick();
    check("ld_send1_hold", cram_rdata, 32'hC0DE0009);
    cram_rready = 1'b1;
    tick();
    ld_valid = 1'b0;
    check("ld_idle_arready", 32'(cram_arready), 32'd1);
    send_ar(4'd4, 32'h20, 8'd1, 3'h2);
    recv_beat("reread0", 32'h55550008, 2'b00, 1'b0, 1'b0);
    recv_beat("reread1", 32'h55550009, 2'b00, 1'b1, 1'b0);

    // Reset during the second beat of a 4-beat burst
    send_ar(4'd7, 32'h0, 8'd3, 3'h2);
    recv_beat("mid0", 32'hC0DE0000, 2'b00, 1'b0, 1'b0);
    cram_rready = 1'b0;
    tick();
    check("mid1_rvalid", 32'(cram_rvalid), 32'd1);
    check("mid1_data", cram_rdata, 32'hC0DE0001);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(cram_rvalid), 32'd0);
    check("mid_rst_rdata", cram_rdata, 32'd0);
    check("mid_rst_rid", 32'(cram_rid), 32'd0);
    check("mid_rst_rlast", 32'(cram_rlast), 32'd0);
    check("mid_rst_rresp", 32'(cram_rresp), 32'd0);
    check("mid_rst_arready", 32'(cram_arready), 32'd0);
    check("mid_rst_ldready", 32'(ld_ready), 32'd0);
    tick();
    nrst = 1'b1;
    tick();
    check("post_rst_arready", 32'(cram_arready), 32'd1);
    cram_rready = 1'b1;
    send_ar(4'd6, 32'h10, 8'd1, 3'h2);
    recv_beat("post0", 32'hC0DE0004, 2'b00, 1'b0, 1'b0);
    recv_beat("post1", 32'hC0DE0005, 2'b00, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
